// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO map, STATUS layout, decode selector.
package data_mem_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;

  localparam logic [31:0] OFF_GPIO   = 32'h0000_0000;
  localparam logic [31:0] OFF_TIMER  = 32'h0000_0004;
  localparam logic [31:0] OFF_TCMP   = 32'h0000_0008;
  localparam logic [31:0] OFF_TXDATA = 32'h0000_000C;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0010;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_IRQ       = 2;
  localparam int unsigned ST_ALIGN     = 3;
  localparam int unsigned ST_COUNT     = 4;
  localparam int unsigned ST_COUNT_W   = 3;
  localparam int unsigned ST_OVF       = 7;
  localparam int unsigned ST_UNMAP     = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_TIMER,
    SEL_TCMP,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  // Word-granular match of a byte address against one MMIO register.
  function automatic logic mmio_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] off);
    logic [31:0] reg_addr;
    reg_addr = base + off;
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// Console TX FIFO: push with full flag, valid/ready pop, registered occupancy count.
module data_mem_responder_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       full,
  input  logic                       ready,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop;
  logic             push_ok;

  assign valid   = count != '0;
  assign full    = count == CW'(DEPTH);
  assign data    = mem[rd_ptr];
  assign pop     = valid && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the rv32i core: word RAM plus GPIO, timer/compare IRQ and console TX MMIO.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned GPIO_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_data_to_mem,
  output logic [31:0]       mem_data_from_mem,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [DEPTH];
  logic [AW-1:0]     ram_idx;
  sel_e              sel;
  logic [31:0]       timer_q, timer_d, tcmp_q, tcmp_d;
  logic [GPIO_W-1:0] gpio_d;
  logic              irq_d;
  logic              align_q, align_d, ovf_q, ovf_d, unmap_q, unmap_d;
  logic              status_wr, fifo_push, fifo_full, fifo_drop;
  logic [CW-1:0]     fifo_count;
  logic [ST_COUNT_W-1:0] count_disp;
  logic [31:0]       status;

  assign ram_idx = mem_address[AW+1:2];

  // Address decode on the aligned word.
  always_comb begin
    sel = SEL_NONE;
    if (mem_address[31:AW+2] == '0)                        sel = SEL_RAM;
    else if (mmio_hit(mem_address, MMIO_BASE, OFF_GPIO))   sel = SEL_GPIO;
    else if (mmio_hit(mem_address, MMIO_BASE, OFF_TIMER))  sel = SEL_TIMER;
    else if (mmio_hit(mem_address, MMIO_BASE, OFF_TCMP))   sel = SEL_TCMP;
    else if (mmio_hit(mem_address, MMIO_BASE, OFF_TXDATA)) sel = SEL_TXDATA;
    else if (mmio_hit(mem_address, MMIO_BASE, OFF_STATUS)) sel = SEL_STATUS;
  end

  always_ff @(posedge clk) begin
    if (mem_write && sel == SEL_RAM) ram[ram_idx] <= mem_data_to_mem;
  end

  assign fifo_push = mem_write && sel == SEL_TXDATA;
  assign fifo_drop = fifo_push && fifo_full && !(tx_valid && tx_ready);
  assign status_wr = mem_write && sel == SEL_STATUS;

  data_mem_responder_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_data_to_mem[7:0]),
    .full      (fifo_full),
    .ready     (tx_ready),
    .valid     (tx_valid),
    .data      (tx_data),
    .count     (fifo_count)
  );

  // Next state for GPIO, timer, compare IRQ and sticky error bits.
  always_comb begin
    gpio_d  = (mem_write && sel == SEL_GPIO) ? mem_data_to_mem[GPIO_W-1:0] : gpio_out;
    timer_d = (mem_write && sel == SEL_TIMER) ? mem_data_to_mem : timer_q + 32'd1;
    tcmp_d  = (mem_write && sel == SEL_TCMP) ? mem_data_to_mem : tcmp_q;
    // Compare against the value the timer takes this edge so irq and count==TCMP coincide.
    irq_d   = !(mem_write && sel == SEL_TCMP) && (timer_irq || timer_d == tcmp_q);
    align_d = (align_q && !status_wr) || ((mem_read || mem_write) && mem_address[1:0] != 2'b00);
    ovf_d   = (ovf_q && !status_wr) || fifo_drop;
    unmap_d = (unmap_q && !status_wr) || (mem_write && sel == SEL_NONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out  <= '0;
      timer_q   <= '0;
      tcmp_q    <= 32'hFFFF_FFFF;
      timer_irq <= 1'b0;
      align_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unmap_q   <= 1'b0;
    end else begin
      gpio_out  <= gpio_d;
      timer_q   <= timer_d;
      tcmp_q    <= tcmp_d;
      timer_irq <= irq_d;
      align_q   <= align_d;
      ovf_q     <= ovf_d;
      unmap_q   <= unmap_d;
    end
  end

  always_comb begin
    count_disp = (32'(fifo_count) > 32'd7) ? ST_COUNT_W'(7) : ST_COUNT_W'(fifo_count);
    status                            = '0;
    status[ST_EMPTY]                  = !tx_valid;
    status[ST_FULL]                   = fifo_full;
    status[ST_IRQ]                    = timer_irq;
    status[ST_ALIGN]                  = align_q;
    status[ST_COUNT +: ST_COUNT_W]    = count_disp;
    status[ST_OVF]                    = ovf_q;
    status[ST_UNMAP]                  = unmap_q;
  end

  // Combinational load path; same-cycle stores are not yet visible.
  always_comb begin
    mem_data_from_mem = '0;
    if (mem_read) begin
      case (sel)
        SEL_RAM:    mem_data_from_mem = ram[ram_idx];
        SEL_GPIO:   mem_data_from_mem = 32'(gpio_out);
        SEL_TIMER:  mem_data_from_mem = timer_q;
        SEL_TCMP:   mem_data_from_mem = tcmp_q;
        SEL_STATUS: mem_data_from_mem = status;
        default:    mem_data_from_mem = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: RAM, GPIO, timer IRQ, TX FIFO, unmapped/sticky bits.
module tb_data_mem_responder;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_GPIO = BASE;
  localparam logic [31:0] A_TMR  = BASE + 32'h4;
  localparam logic [31:0] A_TCMP = BASE + 32'h8;
  localparam logic [31:0] A_TX   = BASE + 32'hC;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_data_to_mem = '0;
  logic [31:0] mem_data_from_mem;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  data_mem_responder dut (
    .clk               (clk),
    .rst               (rst),
    .mem_write         (mem_write),
    .mem_read          (mem_read),
    .mem_address       (mem_address),
    .mem_data_to_mem   (mem_data_to_mem),
    .mem_data_from_mem (mem_data_from_mem),
    .gpio_out          (gpio_out),
    .timer_irq         (timer_irq),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one bus cycle at the falling edge; it commits at the following rising edge.
  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write       = w;
    mem_read        = r;
    mem_address     = a;
    mem_data_to_mem = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    mem_read = 1'b1; mem_address = A_STAT;
    #1;
    check("rst_status", mem_data_from_mem, 32'h1);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    mem_read = 1'b0;
    @(negedge clk) rst = 1'b1;

    // RAM
    drive(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    check("ram_rd", mem_data_from_mem, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 32'h40, 32'h1234_5678);
    check("ram_rd_pre_write", mem_data_from_mem, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    check("ram_rd_new", mem_data_from_mem, 32'h1234_5678);
    drive(1'b0, 1'b0, 32'h40, 32'h0);
    check("rd_strobe_low", mem_data_from_mem, 32'h0);
    drive(1'b0, 1'b1, 32'h42, 32'h0);
    check("ram_rd_misaligned", mem_data_from_mem, 32'h1234_5678);
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("status_align", mem_data_from_mem, 32'h9);
    drive(1'b1, 1'b0, A_STAT, 32'h0);
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("status_align_clr", mem_data_from_mem, 32'h1);

    // GPIO
    drive(1'b1, 1'b0, A_GPIO, 32'h1A5);
    idle();
    check("gpio_out", 32'(gpio_out), 32'hA5);
    drive(1'b0, 1'b1, A_GPIO, 32'h0);
    check("gpio_rd", mem_data_from_mem, 32'hA5);
    idle();
    @(negedge clk) rst = 1'b0;
    #1;
    check("gpio_rst", 32'(gpio_out), 32'h0);
    @(negedge clk) rst = 1'b1;
    drive(1'b0, 1'b1, A_TCMP, 32'h0);
    check("tcmp_rst", mem_data_from_mem, 32'hFFFF_FFFF);

    // Timer / compare IRQ
    drive(1'b1, 1'b0, A_TMR, 32'h0);
    drive(1'b1, 1'b0, A_TCMP, 32'd10);
    drive(1'b0, 1'b1, A_TMR, 32'h0);
    check("timer_after_load", mem_data_from_mem, 32'd1);
    check("irq_early", 32'(timer_irq), 32'h0);
    for (int i = 0; i < 8; i++) idle();
    check("irq_before_match", 32'(timer_irq), 32'h0);
    drive(1'b0, 1'b1, A_TMR, 32'h0);
    check("timer_at_match", mem_data_from_mem, 32'd10);
    check("irq_rise", 32'(timer_irq), 32'h1);
    drive(1'b1, 1'b0, A_TCMP, 32'd100);
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("irq_clr", 32'(timer_irq), 32'h0);
    check("status_irq_clr", mem_data_from_mem, 32'h1);
    drive(1'b1, 1'b0, A_TCMP, 32'hFFFF_FFFF);

    // FIFO overflow and drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, A_TX, 32'h41 + 32'(i));
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("status_full_ovf", mem_data_from_mem, 32'hC2);
    drive(1'b0, 1'b1, A_TX, 32'h0);
    check("txdata_rd", mem_data_from_mem, 32'h0);
    check("tx_head", 32'(tx_data), 32'h41);
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(tx_valid), 32'h1);
      check("drain_data", 32'(tx_data), 32'h41 + 32'(i));
      @(negedge clk);
      #1;
    end
    check("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("status_ovf_sticky", mem_data_from_mem, 32'h81);
    drive(1'b1, 1'b0, A_STAT, 32'h0);
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("status_ovf_clr", mem_data_from_mem, 32'h1);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, A_TX, 32'h50 + 32'(i));
    drive(1'b1, 1'b0, A_TX, 32'h54);
    tx_ready = 1'b1;
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    tx_ready = 1'b0;
    check("status_pushpop", mem_data_from_mem, 32'h42);
    check("pushpop_head", 32'(tx_data), 32'h51);
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pushpop_drain", 32'(tx_data), 32'h51 + 32'(i));
      @(negedge clk);
      #1;
    end
    check("pushpop_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Unmapped accesses and sticky clear
    drive(1'b1, 1'b0, A_GPIO, 32'h3C);
    drive(1'b1, 1'b0, 32'h2000_0000, 32'h77);
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("status_unmap", mem_data_from_mem, 32'h101);
    check("unmap_gpio_kept", 32'(gpio_out), 32'h3C);
    drive(1'b0, 1'b1, 32'h2000_0000, 32'h0);
    check("unmap_rd", mem_data_from_mem, 32'h0);
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h0);
    check("unmap_rd_page", mem_data_from_mem, 32'h0);
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    check("unmap_ram_kept", mem_data_from_mem, 32'h1234_5678);
    drive(1'b1, 1'b0, A_STAT, 32'h0);
    drive(1'b0, 1'b1, A_STAT, 32'h0);
    check("status_unmap_clr", mem_data_from_mem, 32'h1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
